adder_share_arbiter: RTL and testbench



---
 rtl/adder_share_arbiter_pkg.sv | 15 +
 rtl/adder_share_arbiter_decoder_1to2.sv | 18 +
 rtl/adder_share_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants for the two-channel adder arbiter: FSM encoding, channel ids
// and the default datapath width.
package adder_share_arbiter_pkg;

  localparam int ADD_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/adder_share_arbiter_decoder_1to2.sv
// 1-to-2 decoder with enable; turns a registered channel index into a one-hot vector.
module decoder_1to2 (
  input  logic       sel,
  input  logic       en,
  output logic [1:0] y
);

  // Decode sel into a one-hot pair, all-zero when disabled.
  always_comb begin
    y = 2'b00;
    if (en) begin
      y = sel ? 2'b10 : 2'b01;
    end else begin
      y = 2'b00;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one ripple adder between two valid/ready requesters.
// Optional macro ADDER_OVF_FLAG_EN adds the registered signed-overflow output res_ovf.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic         req_cin0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic         req_cin1,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic [1:0]   gnt_onehot
`ifdef ADDER_OVF_FLAG_EN
  , output logic       res_ovf
`endif
);

  state_t       state_r;
  state_t       state_nxt_s;
  logic         last_gnt_r;
  logic         gnt_valid_r;
  logic         can_accept_s;
  logic         gnt_s;
  logic         gnt_idx_s;
  logic [W-1:0] a_sel_s;
  logic [W-1:0] b_sel_s;
  logic         cin_sel_s;
  logic [W:0]   sum_s;

  function automatic logic [W:0] ripple_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
    logic         c;
    logic [W-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  assign can_accept_s = (state_r == ST_IDLE) | ((state_r == ST_BUSY) & res_ready);

  // Round-robin pick: a lone requester wins; on a tie the channel not served last wins.
  always_comb begin
    gnt_s     = 1'b0;
    gnt_idx_s = CH0;
    if (can_accept_s) begin
      case (req_valid)
        2'b01: begin
          gnt_s     = 1'b1;
          gnt_idx_s = CH0;
        end
        2'b10: begin
          gnt_s     = 1'b1;
          gnt_idx_s = CH1;
        end
        2'b11: begin
          gnt_s     = 1'b1;
          gnt_idx_s = ~last_gnt_r;
        end
        default: begin
          gnt_s     = 1'b0;
          gnt_idx_s = CH0;
        end
      endcase
    end else begin
      gnt_s     = 1'b0;
      gnt_idx_s = CH0;
    end
  end

  // Steer the granted operands into the single shared adder.
  always_comb begin
    a_sel_s   = req_a0;
    b_sel_s   = req_b0;
    cin_sel_s = req_cin0;
    if (gnt_idx_s == CH1) begin
      a_sel_s   = req_a1;
      b_sel_s   = req_b1;
      cin_sel_s = req_cin1;
    end else begin
      a_sel_s   = req_a0;
      b_sel_s   = req_b0;
      cin_sel_s = req_cin0;
    end
  end

  assign sum_s = ripple_add(a_sel_s, b_sel_s, cin_sel_s);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a grant always lands a result; a drained result with no grant returns to idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s) state_nxt_s = ST_BUSY;
        else       state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (gnt_s)          state_nxt_s = ST_BUSY;
        else if (res_ready) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_BUSY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: accept strobe follows the grant; held low while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && gnt_s) begin
      req_ready = (gnt_idx_s == CH1) ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign res_valid = (state_r == ST_BUSY);

  // Result and arbitration-history registers, loaded only on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_id      <= CH0;
      res_sum     <= {W{1'b0}};
      res_cout    <= 1'b0;
      last_gnt_r  <= CH1;
      gnt_valid_r <= 1'b0;
    end else if (gnt_s) begin
      res_id      <= gnt_idx_s;
      res_sum     <= sum_s[W-1:0];
      res_cout    <= sum_s[W];
      last_gnt_r  <= gnt_idx_s;
      gnt_valid_r <= 1'b1;
    end else begin
      res_id      <= res_id;
      res_sum     <= res_sum;
      res_cout    <= res_cout;
      last_gnt_r  <= last_gnt_r;
      gnt_valid_r <= gnt_valid_r;
    end
  end

`ifdef ADDER_OVF_FLAG_EN
  // Signed overflow: same-sign operands producing a result of the other sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ovf <= 1'b0;
    end else if (gnt_s) begin
      res_ovf <= (a_sel_s[W-1] == b_sel_s[W-1]) & (sum_s[W-1] != a_sel_s[W-1]);
    end else begin
      res_ovf <= res_ovf;
    end
  end
`endif

  decoder_1to2 u_gnt_dec (
    .sel (res_id),
    .en  (gnt_valid_r),
    .y   (gnt_onehot)
  );

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: stimulus pushes hand-computed results into a
// scoreboard queue, a monitor pops and compares whenever a result is consumed.
module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic       req_cin0, req_cin1;
  logic       res_valid, res_ready, res_id, res_cout;
  logic [7:0] res_sum;
  logic [1:0] gnt_onehot;
`ifdef ADDER_OVF_FLAG_EN
  logic       res_ovf;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int pushed = 0;
  int popped = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  adder_share_arbiter #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_cin0   (req_cin0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_cin1   (req_cin1),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .gnt_onehot (gnt_onehot)
`ifdef ADDER_OVF_FLAG_EN
    , .res_ovf  (res_ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle: drive, check req_ready at negedge, record the expected result if accepted.
  task automatic step(input logic [1:0] v,
                      input logic [7:0] a0, input logic [7:0] b0, input logic c0,
                      input logic [7:0] a1, input logic [7:0] b1, input logic c1,
                      input logic rr, input logic [1:0] exp_rdy, input logic [8:0] exp_cs);
    req_valid = v;
    req_a0 = a0; req_b0 = b0; req_cin0 = c0;
    req_a1 = a1; req_b1 = b1; req_cin1 = c1;
    res_ready = rr;
    @(negedge clk);
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    if (exp_rdy != 2'b00) begin
      sb.push_back({exp_rdy[1], exp_cs});
      pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed result must match the oldest outstanding expectation.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_result: got id=%0d sum=0x%0h, expected no result", res_id, res_sum);
        end else begin
          e = sb.pop_front();
          popped++;
          chk("res_id", {31'd0, res_id}, {31'd0, e[9]});
          chk("res_cout", {31'd0, res_cout}, {31'd0, e[8]});
          chk("res_sum", {24'd0, res_sum}, {24'd0, e[7:0]});
          chk("gnt_onehot", {30'd0, gnt_onehot}, e[9] ? 32'd2 : 32'd1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b0;
    req_a0 = 8'h00; req_b0 = 8'h00; req_cin0 = 1'b0;
    req_a1 = 8'h00; req_b1 = 8'h00; req_cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_sum", {24'd0, res_sum}, 32'd0);
    chk("rst_gnt_onehot", {30'd0, gnt_onehot}, 32'd0);
    rst_n = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("idle_req_ready", {30'd0, req_ready}, 32'd0);
    chk("idle_res_valid", {31'd0, res_valid}, 32'd0);
    chk("idle_res_id", {31'd0, res_id}, 32'd0);
    chk("idle_res_cout", {31'd0, res_cout}, 32'd0);
    chk("idle_gnt_onehot", {30'd0, gnt_onehot}, 32'd0);
    @(posedge clk);
    #1;

    // Single ch0 request, then drain.
    step(2'b01, 8'h12, 8'h34, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 9'h047);
    step(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 9'h000);
    chk("drained_res_valid", {31'd0, res_valid}, 32'd0);
    chk("held_gnt_onehot", {30'd0, gnt_onehot}, 32'd1);

    // Continuous tie: grants alternate starting with ch1 (ch0 served last).
    step(2'b11, 8'h01, 8'h02, 1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 2'b10, 9'h031);
    step(2'b11, 8'h05, 8'h06, 1'b1, 8'h20, 8'h30, 1'b0, 1'b1, 2'b01, 9'h00C);
    step(2'b11, 8'h07, 8'h07, 1'b0, 8'h33, 8'h44, 1'b0, 1'b1, 2'b10, 9'h077);
    step(2'b11, 8'h80, 8'h80, 1'b0, 8'h40, 8'h40, 1'b1, 1'b1, 2'b01, 9'h100);

    // Ch1 wrap-around, then held with res_ready low while ch0 waits.
    step(2'b10, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 2'b10, 9'h100);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 9'h000);
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_id", {31'd0, res_id}, 32'd1);
      chk("hold_res_sum", {24'd0, res_sum}, 32'd0);
      chk("hold_res_cout", {31'd0, res_cout}, 32'd1);
    end
    step(2'b01, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 9'h033);

    // Signed overflow case on ch1, then drain.
    step(2'b10, 8'h00, 8'h00, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b1, 2'b10, 9'h080);
`ifdef ADDER_OVF_FLAG_EN
    chk("res_ovf", {31'd0, res_ovf}, 32'd1);
`endif
    step(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 9'h000);
    chk("after_ovf_gnt_onehot", {30'd0, gnt_onehot}, 32'd2);

    // Reset while a result is held: it vanishes at once and is never delivered.
    step(2'b01, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 9'h002);
    chk("busy_res_valid", {31'd0, res_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("async_rst_res_sum", {24'd0, res_sum}, 32'd0);
    chk("async_rst_gnt_onehot", {30'd0, gnt_onehot}, 32'd0);
    pushed = pushed - sb.size();
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b11, 8'h0A, 8'h0B, 1'b0, 8'h01, 8'h01, 1'b1, 1'b1, 2'b01, 9'h015);
    step(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 9'h000);

    repeat (2) @(posedge clk);
    #1;
    chk("results_delivered", popped, pushed);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
